// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, field-position and IF/ID state definitions
package cpu_pkg;

    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    // Logical immediates are zero-extended; everything else sign-extends.
    function automatic logic sign_extend_sel(input logic [5:0] op);
        return !(op == OP_ANDI || op == OP_ORI || op == OP_XORI || op == OP_LUI);
    endfunction

endpackage

// File: rtl/instr_field_split.sv
// rtl/instr_field_split.sv - combinational MIPS instruction field slicer
module instr_field_split
    import cpu_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [5:0]  op_o,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  shamt_o,
    output logic [5:0]  funct_o,
    output logic [15:0] imm16_o,
    output logic        extend_o
);

    assign op_o     = instr_i[OP_MSB:OP_LSB];
    assign rs_o     = instr_i[RS_MSB:RS_LSB];
    assign rt_o     = instr_i[RT_MSB:RT_LSB];
    assign rd_o     = instr_i[RD_MSB:RD_LSB];
    assign shamt_o  = instr_i[SHAMT_MSB:SHAMT_LSB];
    assign funct_o  = instr_i[FUNCT_MSB:FUNCT_LSB];
    assign imm16_o  = instr_i[IMM_MSB:IMM_LSB];
    assign extend_o = sign_extend_sel(instr_i[OP_MSB:OP_LSB]);

endmodule

// File: rtl/if_id_skid_stage.sv
// rtl/if_id_skid_stage.sv - IF/ID register with one-entry skid buffer and flush
// Optional bubble counter output enabled by IF_ID_BUBBLE_CNT_EN.
module if_id_skid_stage
    import cpu_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [INSTR_W-1:0] in_instr_i,
    input  logic [PC_W-1:0]    in_pc4_i,
    input  logic               flush_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [INSTR_W-1:0] out_instr_o,
    output logic [PC_W-1:0]    out_pc4_o,
    output logic [5:0]         op_o,
    output logic [4:0]         rs_o,
    output logic [4:0]         rt_o,
    output logic [4:0]         rd_o,
    output logic [4:0]         shamt_o,
    output logic [5:0]         funct_o,
    output logic [15:0]        imm16_o,
    output logic               extend_o
`ifdef IF_ID_BUBBLE_CNT_EN
    ,
    output logic [31:0]        bubble_cnt_o
`endif
);

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    main_pc4_q, main_pc4_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    skid_pc4_q, skid_pc4_d;
    logic               in_fire, out_fire;

    assign in_fire  = in_valid_i & in_ready_q;
    assign out_fire = (state_q != EMPTY) & out_ready_i;

    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc4_d   = main_pc4_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d      = ONE;
                        main_instr_d = in_instr_i;
                        main_pc4_d   = in_pc4_i;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        state_d      = TWO;
                        skid_instr_d = in_instr_i;
                        skid_pc4_d   = in_pc4_i;
                    end else if (in_fire && out_fire) begin
                        main_instr_d = in_instr_i;
                        main_pc4_d   = in_pc4_i;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_d      = ONE;
                        main_instr_d = skid_instr_q;
                        main_pc4_d   = skid_pc4_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        // Ready is registered from next state so it never depends on out_ready_i.
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= EMPTY;
            in_ready_q   <= 1'b1;
            main_instr_q <= '0;
            main_pc4_q   <= '0;
            skid_instr_q <= '0;
            skid_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            main_instr_q <= main_instr_d;
            main_pc4_q   <= main_pc4_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q != EMPTY);
    assign out_instr_o = main_instr_q;
    assign out_pc4_o   = main_pc4_q;

    instr_field_split u_split (
        .instr_i  (main_instr_q[31:0]),
        .op_o     (op_o),
        .rs_o     (rs_o),
        .rt_o     (rt_o),
        .rd_o     (rd_o),
        .shamt_o  (shamt_o),
        .funct_o  (funct_o),
        .imm16_o  (imm16_o),
        .extend_o (extend_o)
    );

`ifdef IF_ID_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // The flush cycle itself is excluded; the empty cycles after it count.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (state_q == EMPTY && !flush_i) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// tb/tb_if_id_skid_stage.sv - self-checking bench for if_id_skid_stage
module tb_if_id_skid_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc4;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic        extend;
`ifdef IF_ID_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    always #5 clk = ~clk;

    if_id_skid_stage #(.PC_W(32), .INSTR_W(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_instr_i  (in_instr),
        .in_pc4_i    (in_pc4),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_instr_o (out_instr),
        .out_pc4_o   (out_pc4),
        .op_o        (op),
        .rs_o        (rs),
        .rt_o        (rt),
        .rd_o        (rd),
        .shamt_o     (shamt),
        .funct_o     (funct),
        .imm16_o     (imm16),
        .extend_o    (extend)
`ifdef IF_ID_BUBBLE_CNT_EN
        ,
        .bubble_cnt_o(bubble_cnt)
`endif
    );

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic        ext;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ent_t;

    vec_t vecs[7];
    ent_t sb[$];
    ent_t drained[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: update the reference queue from the pre-edge handshake, then compare.
    task automatic step();
        logic in_fire, out_fire;
        ent_t e;
        @(posedge clk);
        in_fire  = in_valid && (sb.size() != 2);
        out_fire = (sb.size() != 0) && out_ready;
        if (flush) begin
            sb.delete();
        end else begin
            if (out_fire) begin
                e = sb.pop_front();
                drained.push_back(e);
            end
            if (in_fire) begin
                e.instr = in_instr;
                e.pc4   = in_pc4;
                sb.push_back(e);
            end
        end
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, sb.size() != 2});
        if (sb.size() != 0) begin
            chk("out_instr", out_instr, sb[0].instr);
            chk("out_pc4", out_pc4, sb[0].pc4);
        end
    endtask

    task automatic offer(input logic v, input logic [31:0] instr, input logic [31:0] pc4);
        in_valid = v;
        in_instr = instr;
        in_pc4   = pc4;
    endtask

    initial begin
        vecs[0] = '{32'h2008FFFF, 6'h08, 5'd0,  5'd8,  5'h1F, 5'h1F, 6'h3F, 16'hFFFF, 1'b1};
        vecs[1] = '{32'h3508FFFF, 6'h0D, 5'd8,  5'd8,  5'h1F, 5'h1F, 6'h3F, 16'hFFFF, 1'b0};
        vecs[2] = '{32'h012A4020, 6'h00, 5'd9,  5'd10, 5'd8,  5'd0,  6'h20, 16'h4020, 1'b1};
        vecs[3] = '{32'h3C01ABCD, 6'h0F, 5'd0,  5'd1,  5'h15, 5'h0F, 6'h0D, 16'hABCD, 1'b0};
        vecs[4] = '{32'h300000FF, 6'h0C, 5'd0,  5'd0,  5'd0,  5'd3,  6'h3F, 16'h00FF, 1'b0};
        vecs[5] = '{32'h39CE1234, 6'h0E, 5'd14, 5'd14, 5'd2,  5'd8,  6'h34, 16'h1234, 1'b0};
        vecs[6] = '{32'h8D090010, 6'h23, 5'd8,  5'd9,  5'd0,  5'd0,  6'h10, 16'h0010, 1'b1};

        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        offer(1'b0, 32'h0, 32'h0);
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_extend", {31'd0, extend}, 32'd1);
        chk("rst_imm16", {16'd0, imm16}, 32'd0);
        chk("rst_op", {26'd0, op}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        repeat (5) step();
`ifdef IF_ID_BUBBLE_CNT_EN
        chk("bubble_cnt_5", bubble_cnt, 32'd5);
`endif

        for (int i = 0; i < 7; i++) begin
            out_ready = 1'b1;
            offer(1'b1, vecs[i].instr, 32'(4 * (i + 1)));
            step();
            chk("fld_op", {26'd0, op}, {26'd0, vecs[i].op});
            chk("fld_rs", {27'd0, rs}, {27'd0, vecs[i].rs});
            chk("fld_rt", {27'd0, rt}, {27'd0, vecs[i].rt});
            chk("fld_rd", {27'd0, rd}, {27'd0, vecs[i].rd});
            chk("fld_shamt", {27'd0, shamt}, {27'd0, vecs[i].shamt});
            chk("fld_funct", {26'd0, funct}, {26'd0, vecs[i].funct});
            chk("fld_imm16", {16'd0, imm16}, {16'd0, vecs[i].imm});
            chk("fld_extend", {31'd0, extend}, {31'd0, vecs[i].ext});
        end
        offer(1'b0, 32'h0, 32'h0);
        step();

        drained.delete();
        out_ready = 1'b0;
        offer(1'b1, 32'hAAAA0001, 32'h100);
        step();
        offer(1'b1, 32'hBBBB0002, 32'h104);
        step();
        offer(1'b1, 32'hCCCC0003, 32'h108);
        step();
        chk("stall_hold_A", out_instr, 32'hAAAA0001);
        chk("stall_ready_low", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        step();
        offer(1'b0, 32'h0, 32'h0);
        step();
        chk("drain_count", 32'(drained.size()), 32'd3);
        if (drained.size() == 3) begin
            chk("drain_order_0", drained[0].instr, 32'hAAAA0001);
            chk("drain_order_1", drained[1].instr, 32'hBBBB0002);
            chk("drain_order_2", drained[2].instr, 32'hCCCC0003);
        end

        out_ready = 1'b0;
        offer(1'b1, 32'hDDDD0004, 32'h200);
        step();
        offer(1'b1, 32'hEEEE0005, 32'h204);
        step();
        offer(1'b1, 32'hFFFF0006, 32'h208);
        flush = 1'b1;
        step();
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        step();
        chk("flush_dropped", {31'd0, out_valid}, 32'd0);

        offer(1'b1, 32'h11110007, 32'h300);
        step();
        offer(1'b1, 32'h3C01ABCD, 32'h304);
        step();
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_extend", {31'd0, extend}, 32'd1);
        chk("midrst_imm16", {16'd0, imm16}, 32'd0);
        offer(1'b0, 32'h0, 32'h0);
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
